// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and helpers for the MIPS pipeline front end
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [31:0] ADDR_MASK_DEF = 32'h1fffffff;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_slot_queue.sv
// if_slot_queue: in-order ring of fetch slots holding PC, instruction and fill state
module if_slot_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter int CW = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              alloc_adel,
  input  logic              fill,
  input  logic [31:0]       fill_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     pend,
  output logic              head_filled,
  output logic              head_adel,
  output logic [ADDR_W-1:0] head_pc,
  output logic [31:0]       head_inst
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [31:0] inst_q [DEPTH];
  logic [DEPTH-1:0] filled_q, adel_q;
  logic [PW-1:0] alloc_ptr, fill_ptr, pop_ptr;
  // head slot is what decode sees
  always_comb begin
    head_filled = filled_q[pop_ptr];
    head_adel = adel_q[pop_ptr];
    head_pc = pc_q[pop_ptr];
    head_inst = inst_q[pop_ptr];
  end
  // slot payload; no reset needed since filled_q qualifies every read
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[alloc_ptr] <= alloc_pc;
      adel_q[alloc_ptr] <= alloc_adel;
    end
    if (fill) inst_q[fill_ptr] <= fill_data;
  end
  // pointers, fill flags and occupancy; an address-error slot is born filled so the fill pointer steps past it
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr <= '0;
      pop_ptr <= '0;
      count <= '0;
      pend <= '0;
      filled_q <= '0;
    end else begin
      if (pop) begin
        filled_q[pop_ptr] <= 1'b0;
        pop_ptr <= pop_ptr + PW'(1);
      end
      if (alloc) begin
        filled_q[alloc_ptr] <= alloc_adel;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill) filled_q[fill_ptr] <= 1'b1;
      if (fill || (alloc && alloc_adel)) fill_ptr <= fill_ptr + PW'(1);
      count <= count + CW'(alloc) - CW'(pop);
      pend <= pend + CW'(alloc & ~alloc_adel) - CW'(fill);
    end
  end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: pipelined instruction fetch with in-order prefetch queue and redirect flush
module if_prefetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(ADDR_MASK_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_adel
);
  localparam int CW = cnt_w(DEPTH);
  logic [ADDR_W-1:0] fetch_pc, head_pc;
  logic [CW-1:0] discard, count, pend, discard_flush;
  logic [CW:0] in_use;
  logic [31:0] head_inst;
  logic halt, misaligned, accept, adel_alloc, drop, fill, pop, head_filled, head_adel;
  if_slot_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .alloc((accept | adel_alloc) & ~redirect_valid),
    .alloc_pc(fetch_pc),
    .alloc_adel(adel_alloc),
    .fill(fill),
    .fill_data(inst_rdata),
    .pop(pop),
    .count(count),
    .pend(pend),
    .head_filled(head_filled),
    .head_adel(head_adel),
    .head_pc(head_pc),
    .head_inst(head_inst)
  );
  // bus handshake, queue control and decode-side presentation
  always_comb begin
    misaligned = fetch_pc[1:0] != 2'b00;
    in_use = {1'b0, count} + {1'b0, discard};
    inst_req = ~reset & ~halt & ~misaligned & (in_use < (CW+1)'(DEPTH));
    inst_addr = fetch_pc & ADDR_MASK;
    accept = inst_req & inst_addr_ok;
    adel_alloc = ~reset & ~halt & misaligned & ~redirect_valid & (count < CW'(DEPTH));
    drop = inst_data_ok & (discard != '0);
    fill = inst_data_ok & ~drop & ~redirect_valid;
    out_valid = head_filled & ~redirect_valid;
    pop = out_valid & out_ready;
    out_pc = out_valid ? head_pc : '0;
    out_adel = out_valid & head_adel;
    out_inst = (out_valid & ~head_adel) ? head_inst : 32'h0;
    discard_flush = discard + pend + CW'(accept) - CW'(inst_data_ok);
  end
  // fetch PC, stale-response debt and address-error halt
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      discard <= '0;
      halt <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      discard <= discard_flush;
      halt <= 1'b0;
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (drop) discard <= discard - CW'(1);
      if (adel_alloc) halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed vectors plus randomized bus/redirect stream against a PC-sequence model
module tb_if_prefetch;
  localparam logic [31:0] MASK = 32'h1fffffff;
  localparam logic [31:0] RPC = 32'hbfc00000;
  logic clk = 1'b0, reset = 1'b1;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_addr, inst_rdata = '0;
  logic out_valid, out_ready = 1'b0, out_adel;
  logic [31:0] out_inst, out_pc;

  if_prefetch dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0, cyc = 0;
  int lat_fix = 0;
  logic lat_rnd = 0, aok_rnd = 0, aok_en = 1;
  logic [31:0] pq[$];
  int due[$];
  logic [31:0] exp_pc = RPC;
  logic exp_halt = 0;
  logic s_req, s_acc, s_dok, s_valid, s_adel, s_pop, s_redir, s_reset;
  logic [31:0] s_addr, s_pc, s_inst, s_rpc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h24000000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    logic ea;
    @(negedge clk);
    inst_addr_ok = aok_en & (aok_rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
    if (pq.size() != 0 && due[0] <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata = mem(pq[0]);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata = $urandom;
    end
    #1;
    s_req = inst_req; s_addr = inst_addr; s_acc = inst_req & inst_addr_ok; s_dok = inst_data_ok;
    s_valid = out_valid; s_pc = out_pc; s_inst = out_inst; s_adel = out_adel;
    s_pop = out_valid & out_ready; s_redir = redirect_valid; s_rpc = redirect_pc; s_reset = reset;
    if (s_redir) chk("valid_in_redirect", {31'b0, s_valid}, 32'h0);
    if (s_pop) begin
      if (exp_halt) begin
        n_chk++;
        $display("FAIL pop_while_halted: got pc %h expected no output (cycle %0d)", s_pc, cyc);
      end else begin
        ea = exp_pc[1:0] != 2'b00;
        chk("out_pc", s_pc, exp_pc);
        chk("out_adel", {31'b0, s_adel}, {31'b0, ea});
        chk("out_inst", s_inst, ea ? 32'h0 : mem(exp_pc & MASK));
        if (ea) exp_halt = 1'b1;
        else exp_pc = exp_pc + 32'd4;
      end
    end
    n_acc += int'(s_acc);
    n_pop += int'(s_pop);
    @(posedge clk);
    #1;
    cyc++;
    if (s_reset) begin
      pq.delete(); due.delete();
      exp_pc = RPC; exp_halt = 1'b0;
    end else begin
      if (s_dok) begin void'(pq.pop_front()); void'(due.pop_front()); end
      if (s_acc) begin
        pq.push_back(s_addr);
        due.push_back(cyc + lat_fix + (lat_rnd ? int'($urandom_range(0, 4)) : 0));
      end
      if (s_redir) begin exp_pc = s_rpc; exp_halt = 1'b0; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic rdy;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tv[13];

  initial begin
    int a0, p0;
    tv[0]  = '{1'b1, 1'b1, 32'h1fc00000, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 1'b1, 32'h1fc00004, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 1'b1, 32'h1fc00008, 1'b1, 32'hbfc00000};
    tv[3]  = '{1'b1, 1'b1, 32'h1fc0000c, 1'b1, 32'hbfc00004};
    tv[4]  = '{1'b1, 1'b1, 32'h1fc00010, 1'b1, 32'hbfc00008};
    tv[5]  = '{1'b1, 1'b1, 32'h1fc00014, 1'b1, 32'hbfc0000c};
    tv[6]  = '{1'b1, 1'b1, 32'h1fc00018, 1'b1, 32'hbfc00010};
    tv[7]  = '{1'b1, 1'b1, 32'h1fc0001c, 1'b1, 32'hbfc00014};
    tv[8]  = '{1'b0, 1'b1, 32'h1fc00020, 1'b1, 32'hbfc00018};
    tv[9]  = '{1'b0, 1'b1, 32'h1fc00024, 1'b1, 32'hbfc00018};
    tv[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00018};
    tv[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hbfc00018};
    tv[12] = '{1'b1, 1'b1, 32'h1fc00028, 1'b1, 32'hbfc0001c};

    step();
    chk("reset_req", {31'b0, s_req}, 32'h0);
    chk("reset_valid", {31'b0, s_valid}, 32'h0);
    chk("reset_adel", {31'b0, s_adel}, 32'h0);
    chk("reset_inst", s_inst, 32'h0);
    chk("reset_pc", s_pc, 32'h0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      out_ready = tv[i].rdy;
      step();
      chk($sformatf("tv%0d_req", i), {31'b0, s_req}, {31'b0, tv[i].req});
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), s_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, s_valid}, {31'b0, tv[i].vld});
      if (tv[i].vld) chk($sformatf("tv%0d_pc", i), s_pc, tv[i].pc);
    end

    do_reset();
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) step();
    chk("stall_accepts", 32'(n_acc - a0), 32'd4);
    chk("stall_req_low", {31'b0, s_req}, 32'h0);
    out_ready = 1'b1;
    p0 = n_pop;
    step();
    chk("full_pop_req_low", {31'b0, s_req}, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("drain_pops", 32'(n_pop - p0), 32'd4);

    do_reset();
    lat_fix = 6;
    a0 = n_acc;
    for (int i = 0; i < 3; i++) step();
    chk("inflight_accepts", 32'(n_acc - a0), 32'd3);
    aok_en = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80000100;
    step();
    redirect_valid = 1'b0; aok_en = 1'b1; lat_fix = 0;
    step();
    chk("redir_req", {31'b0, s_req}, 32'h1);
    chk("redir_addr", s_addr, 32'h00000100);
    p0 = n_pop;
    for (int i = 0; i < 20 && n_pop == p0; i++) step();
    chk("redir_pop_seen", {31'b0, n_pop != p0}, 32'h1);
    chk("redir_first_pc", s_pc, 32'h80000100);
    chk("redir_first_inst", s_inst, mem(32'h00000100));

    for (int i = 0; i < 8; i++) step();
    redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    step();
    chk("same_cycle_acc", {31'b0, s_acc}, 32'h1);
    chk("same_cycle_dok", {31'b0, s_dok}, 32'h1);
    redirect_valid = 1'b0;
    step();
    chk("same_cycle_next_addr", s_addr, 32'h00000200);
    for (int i = 0; i < 8; i++) step();

    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    step();
    redirect_valid = 1'b0;
    step();
    chk("adel_no_req", {31'b0, s_req}, 32'h0);
    chk("adel_not_yet_valid", {31'b0, s_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("adel_valid", {31'b0, s_valid}, 32'h1);
      chk("adel_flag", {31'b0, s_adel}, 32'h1);
      chk("adel_pc", s_pc, 32'h80000102);
      chk("adel_inst", s_inst, 32'h0);
      chk("adel_halt_req", {31'b0, s_req}, 32'h0);
    end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_no_valid", {31'b0, s_valid}, 32'h0);
      chk("halt_no_req", {31'b0, s_req}, 32'h0);
    end

    redirect_valid = 1'b1; redirect_pc = 32'h80001000;
    step();
    redirect_valid = 1'b0;
    aok_rnd = 1'b1; lat_rnd = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 600; i++) begin
      out_ready = $urandom_range(0, 9) < 7;
      redirect_valid = $urandom_range(0, 29) == 0;
      redirect_pc = 32'h80000000 | ($urandom & 32'h0000fffc) |
                    (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("random_progress", {31'b0, (n_pop - p0) > 100}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
